// File: rtl/arc4_mbox_ctrl.sv
// Mailbox controller: polls word 0 for the host start token, launches one ARC4 key
// search, then publishes key bytes (words 2..4) followed by the status flag (word 1).
module arc4_mbox_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int KEY_W    = 24,
  parameter int POLL_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mb_addr,
  output logic [7:0]        mb_wrdata,
  output logic              mb_wren,
  input  logic [7:0]        mb_rddata,
  output logic              srch_start,
  input  logic              srch_done,
  input  logic              srch_found,
  input  logic [KEY_W-1:0]  srch_key,
  output logic              busy,
  output logic [3:0]        state_dbg
);

  localparam logic [3:0] S_POLL_RD   = 4'd0;
  localparam logic [3:0] S_POLL_WT   = 4'd1;
  localparam logic [3:0] S_POLL_CHK  = 4'd2;
  localparam logic [3:0] S_GAP       = 4'd3;
  localparam logic [3:0] S_CLR_TOK   = 4'd4;
  localparam logic [3:0] S_LAUNCH    = 4'd5;
  localparam logic [3:0] S_WAIT_DONE = 4'd6;
  localparam logic [3:0] S_WR_K0     = 4'd7;
  localparam logic [3:0] S_WR_K1     = 4'd8;
  localparam logic [3:0] S_WR_K2     = 4'd9;
  localparam logic [3:0] S_WR_FLAG   = 4'd10;
  localparam logic [3:0] S_FIN       = 4'd11;

  localparam logic [7:0]  START_TOKEN = 8'hFF;
  localparam logic [7:0]  FLAG_FOUND  = 8'hFF;
  localparam logic [7:0]  FLAG_NONE   = 8'h0F;
  localparam bit          NO_GAP      = (POLL_GAP == 0);
  localparam logic [15:0] GAP_LAST    = NO_GAP ? 16'd0 : 16'(POLL_GAP - 1);

  logic [3:0]        state_r, state_nxt;
  logic [15:0]       gap_r, gap_nxt;
  logic [KEY_W-1:0]  key_r, key_nxt;
  logic              found_r, found_nxt;

  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        wrdata_nxt;
  logic              wren_nxt, start_nxt, busy_nxt;

  // Next-state logic; the key and found flag are captured only when WAIT_DONE accepts done.
  always_comb begin
    state_nxt = state_r;
    gap_nxt   = gap_r;
    key_nxt   = key_r;
    found_nxt = found_r;
    case (state_r)
      S_POLL_RD:  state_nxt = S_POLL_WT;
      S_POLL_WT:  state_nxt = S_POLL_CHK;
      S_POLL_CHK: begin
        if (mb_rddata == START_TOKEN) begin
          state_nxt = S_CLR_TOK;
        end else if (NO_GAP) begin
          state_nxt = S_POLL_RD;
        end else begin
          state_nxt = S_GAP;
          gap_nxt   = 16'd0;
        end
      end
      S_GAP: begin
        if (gap_r >= GAP_LAST) begin
          state_nxt = S_POLL_RD;
        end else begin
          gap_nxt = gap_r + 16'd1;
        end
      end
      S_CLR_TOK:  state_nxt = S_LAUNCH;
      S_LAUNCH:   state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (srch_done) begin
          found_nxt = srch_found;
          if (srch_found) begin
            key_nxt   = srch_key;
            state_nxt = S_WR_K0;
          end else begin
            state_nxt = S_WR_FLAG;
          end
        end else begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WR_K0:    state_nxt = S_WR_K1;
      S_WR_K1:    state_nxt = S_WR_K2;
      S_WR_K2:    state_nxt = S_WR_FLAG;
      S_WR_FLAG:  state_nxt = S_FIN;
      S_FIN: begin
        if (!srch_done) begin
          state_nxt = S_POLL_RD;
        end else begin
          state_nxt = S_FIN;
        end
      end
      default:    state_nxt = S_POLL_RD;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with state_r.
  always_comb begin
    addr_nxt   = '0;
    wrdata_nxt = 8'h00;
    wren_nxt   = 1'b0;
    start_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    case (state_nxt)
      S_CLR_TOK: begin
        wren_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_LAUNCH: begin
        start_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_WAIT_DONE: busy_nxt = 1'b1;
      S_WR_K0: begin
        addr_nxt   = ADDR_W'(2'd2);
        wrdata_nxt = key_nxt[KEY_W-1 -: 8];
        wren_nxt   = 1'b1;
        busy_nxt   = 1'b1;
      end
      S_WR_K1: begin
        addr_nxt   = ADDR_W'(2'd3);
        wrdata_nxt = key_nxt[KEY_W-9 -: 8];
        wren_nxt   = 1'b1;
        busy_nxt   = 1'b1;
      end
      S_WR_K2: begin
        addr_nxt   = ADDR_W'(3'd4);
        wrdata_nxt = key_nxt[7:0];
        wren_nxt   = 1'b1;
        busy_nxt   = 1'b1;
      end
      S_WR_FLAG: begin
        addr_nxt   = ADDR_W'(1'd1);
        wrdata_nxt = found_nxt ? FLAG_FOUND : FLAG_NONE;
        wren_nxt   = 1'b1;
        busy_nxt   = 1'b1;
      end
      default: begin
        addr_nxt = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_POLL_RD;
      gap_r      <= 16'd0;
      key_r      <= '0;
      found_r    <= 1'b0;
      mb_addr    <= '0;
      mb_wrdata  <= 8'h00;
      mb_wren    <= 1'b0;
      srch_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      gap_r      <= gap_nxt;
      key_r      <= key_nxt;
      found_r    <= found_nxt;
      mb_addr    <= addr_nxt;
      mb_wrdata  <= wrdata_nxt;
      mb_wren    <= wren_nxt;
      srch_start <= start_nxt;
      busy       <= busy_nxt;
    end
  end

  assign state_dbg = state_r;

endmodule

// File: tb/tb_arc4_mbox_ctrl.sv
// Bench for arc4_mbox_ctrl: mailbox RAM model, scripted search engine, and a
// transaction-level reference of the expected mailbox write sequence per search.
module tb_arc4_mbox_ctrl;
  localparam int ADDR_W = 8;
  localparam int KEY_W = 24;
  localparam int POLL_GAP = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [ADDR_W-1:0] mb_addr;
  logic [7:0] mb_wrdata, mb_rddata;
  logic mb_wren, srch_start, srch_done, srch_found, busy;
  logic [KEY_W-1:0] srch_key;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  arc4_mbox_ctrl #(.ADDR_W(ADDR_W), .KEY_W(KEY_W), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .mb_addr(mb_addr), .mb_wrdata(mb_wrdata),
    .mb_wren(mb_wren), .mb_rddata(mb_rddata), .srch_start(srch_start),
    .srch_done(srch_done), .srch_found(srch_found), .srch_key(srch_key),
    .busy(busy), .state_dbg(state_dbg));

  // Mailbox RAM: registered address, unregistered q; host port yields to the controller.
  logic [7:0] mem [0:255];
  logic [ADDR_W-1:0] rd_addr_q = '0;
  logic host_we;
  logic [7:0] host_addr, host_data;
  assign mb_rddata = mem[rd_addr_q];
  always @(posedge clk) begin
    rd_addr_q <= mb_addr;
    if (mb_wren) mem[mb_addr] <= mb_wrdata;
    else if (host_we) mem[host_addr] <= host_data;
  end

  // Edge-indexed monitor: write log, launch log, poll starts, state-edge coverage.
  int cyc = 0;
  int last_chk = 0;
  logic [15:0] wlog[$];
  int wcyc[$];
  int start_lat[$];
  int start_cyc[$];
  int poll_starts[$];
  logic [3:0] prev_st = 4'd0;
  bit edge_hit [16][16];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mb_wren) begin
      wlog.push_back({mb_addr, mb_wrdata});
      wcyc.push_back(cyc);
    end
    if (srch_start) begin
      start_lat.push_back(cyc - last_chk);
      start_cyc.push_back(cyc);
    end
    if (state_dbg == 4'd2) last_chk <= cyc;
    if (state_dbg == 4'd0 && prev_st != 4'd0) poll_starts.push_back(cyc);
    if (state_dbg != prev_st) edge_hit[prev_st][state_dbg] <= 1'b1;
    prev_st <= state_dbg;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_addr = a; host_data = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (start_lat.size() < n && k < 200) begin @(negedge clk); k++; end
    chk(tag, 32'(start_lat.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Reference: a search publishes token clear, key bytes MSB first if found, flag last.
  task automatic expect_run(input bit found, input logic [23:0] key, input int t_done,
                            input string tag);
    logic [15:0] exp_q[$];
    exp_q.push_back({8'h00, 8'h00});
    if (found) begin
      exp_q.push_back({8'h02, key[23:16]});
      exp_q.push_back({8'h03, key[15:8]});
      exp_q.push_back({8'h04, key[7:0]});
    end
    exp_q.push_back({8'h01, found ? 8'hFF : 8'h0F});
    chk({tag, "_nwr"}, 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(wlog[i]), 32'(exp_q[i]));
    if (t_done >= 0 && wcyc.size() > 0)
      chk({tag, "_lat"}, 32'(wcyc[wcyc.size()-1] - t_done), found ? 32'd4 : 32'd1);
  endtask

  // Drive the engine after a launch: done after `delay`, then perturb the key and idle.
  task automatic run_search(input bit found, input logic [23:0] key, input int delay,
                            input string tag);
    int t_done;
    step(delay);
    srch_key = key; srch_found = found; srch_done = 1'b1;
    t_done = cyc;
    step(1);
    srch_key = ~key;
    wait_idle({tag, "_idle"});
    step(1);
    expect_run(found, key, t_done, tag);
    chk({tag, "_nstart"}, 32'(start_lat.size()), 32'd1);
    srch_done = 1'b0;
    step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] k;
    rst_n = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_data = 8'h00;
    srch_done = 1'b0; srch_found = 1'b0; srch_key = '0;
    @(negedge clk);
    host_wr(8'h00, 8'h00); host_wr(8'h01, 8'h55);
    host_wr(8'h02, 8'hAA); host_wr(8'h03, 8'hAA); host_wr(8'h04, 8'hAA);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_wren", 32'(mb_wren), 32'd0);
    chk("rst_addr", 32'(mb_addr), 32'd0);
    chk("rst_wrdata", 32'(mb_wrdata), 32'd0);
    chk("rst_start", 32'(srch_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Found path with the fixed key
    wlog.delete(); wcyc.delete(); start_lat.delete(); start_cyc.delete();
    host_wr(8'h00, 8'hFF);
    wait_starts(1, "found_start");
    if (start_lat.size() > 0) chk("found_startlat", 32'(start_lat[0]), 32'd2);
    step(50);
    srch_key = 24'h1E4600; srch_found = 1'b1; srch_done = 1'b1;
    begin
      int t_done;
      t_done = cyc;
      step(1);
      srch_key = 24'($urandom);
      wait_idle("found_idle");
      step(1);
      expect_run(1'b1, 24'h1E4600, t_done, "found");
    end
    chk("found_m0", 32'(mem[0]), 32'h00);
    chk("found_m1", 32'(mem[1]), 32'hFF);
    chk("found_m2", 32'(mem[2]), 32'h1E);
    chk("found_m3", 32'(mem[3]), 32'h46);
    chk("found_m4", 32'(mem[4]), 32'h00);
    step(5);
    chk("found_fin_hold", 32'(state_dbg), 32'd11);
    srch_done = 1'b0;
    step(1);
    chk("found_fin_exit", 32'(state_dbg), 32'd0);
    chk("found_nstart", 32'(start_lat.size()), 32'd1);

    // Polling with a random non-token value, then a token
    wlog.delete(); wcyc.delete(); start_lat.delete(); start_cyc.delete();
    host_wr(8'h00, 8'($urandom_range(0, 254)));
    poll_starts.delete();
    step(40);
    chk("poll_nostart", 32'(start_lat.size()), 32'd0);
    chk("poll_count", 32'(poll_starts.size() >= 4), 32'd1);
    for (int i = 1; i < poll_starts.size(); i++)
      chk($sformatf("poll_period%0d", i), 32'(poll_starts[i] - poll_starts[i-1]),
          32'(3 + POLL_GAP));
    host_wr(8'h00, 8'hFF);
    wait_starts(1, "poll_start");
    if (start_lat.size() > 0) chk("poll_startlat", 32'(start_lat[0]), 32'd2);
    run_search(1'b1, 24'($urandom), $urandom_range(0, 20), "poll");

    // Not-found path leaves words 2..4 alone
    host_wr(8'h02, 8'hAA); host_wr(8'h03, 8'hAA); host_wr(8'h04, 8'hAA);
    wlog.delete(); wcyc.delete(); start_lat.delete(); start_cyc.delete();
    host_wr(8'h00, 8'hFF);
    wait_starts(1, "nf_start");
    run_search(1'b0, 24'($urandom), $urandom_range(1, 30), "nf");
    chk("nf_m1", 32'(mem[1]), 32'h0F);
    chk("nf_m2", 32'(mem[2]), 32'hAA);
    chk("nf_m3", 32'(mem[3]), 32'hAA);
    chk("nf_m4", 32'(mem[4]), 32'hAA);

    // Done already high through LAUNCH and left high after the result
    wlog.delete(); wcyc.delete(); start_lat.delete(); start_cyc.delete();
    k = 24'($urandom);
    srch_key = k; srch_found = 1'b1; srch_done = 1'b1;
    step(3);
    host_wr(8'h00, 8'hFF);
    wait_starts(1, "stale_start");
    wait_idle("stale_idle");
    step(1);
    expect_run(1'b1, k, -1, "stale");
    if (start_cyc.size() > 0 && wcyc.size() > 0)
      chk("stale_minlat", 32'(wcyc[wcyc.size()-1] - start_cyc[0]), 32'd5);
    step(20);
    chk("stale_fin_hold", 32'(state_dbg), 32'd11);
    chk("stale_nstart", 32'(start_lat.size()), 32'd1);
    chk("stale_busy", 32'(busy), 32'd0);
    srch_done = 1'b0;
    step(1);
    chk("stale_fin_exit", 32'(state_dbg), 32'd0);

    // Reset asserted while WR_K1 is on the bus
    host_wr(8'h01, 8'h55); host_wr(8'h04, 8'hAA);
    wlog.delete(); wcyc.delete(); start_lat.delete(); start_cyc.delete();
    host_wr(8'h00, 8'hFF);
    wait_starts(1, "rst_start");
    k = 24'($urandom);
    step($urandom_range(1, 10));
    srch_key = k; srch_found = 1'b1; srch_done = 1'b1;
    begin
      int n = 0;
      while (state_dbg !== 4'd8 && n < 50) begin @(negedge clk); n++; end
      chk("rst_reach_k1", 32'(state_dbg), 32'd8);
    end
    rst_n = 1'b0;
    step(1);
    chk("rstmid_state", 32'(state_dbg), 32'd0);
    chk("rstmid_wren", 32'(mb_wren), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; srch_done = 1'b0;
    step(2);
    chk("rstmid_nwr", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("rstmid_wr0", 32'(wlog[0]), 32'h0000);
      chk("rstmid_wr1", 32'(wlog[1]), 32'({8'h02, k[23:16]}));
      chk("rstmid_wr2", 32'(wlog[2]), 32'({8'h03, k[15:8]}));
    end
    chk("rstmid_m4", 32'(mem[4]), 32'hAA);
    chk("rstmid_m1", 32'(mem[1]), 32'h55);
    wlog.delete(); wcyc.delete(); start_lat.delete(); start_cyc.delete();
    host_wr(8'h00, 8'hFF);
    wait_starts(1, "post_start");
    run_search(1'b1, 24'($urandom), $urandom_range(0, 15), "post");

    chk("cov_0_1", 32'(edge_hit[0][1]), 32'd1);
    chk("cov_1_2", 32'(edge_hit[1][2]), 32'd1);
    chk("cov_2_3", 32'(edge_hit[2][3]), 32'd1);
    chk("cov_2_4", 32'(edge_hit[2][4]), 32'd1);
    chk("cov_6_7", 32'(edge_hit[6][7]), 32'd1);
    chk("cov_6_10", 32'(edge_hit[6][10]), 32'd1);
    chk("cov_11_0", 32'(edge_hit[11][0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
